// File: rtl/jmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jmp_ctrl
//  Description : Conditional-jump sequencer: keeps the ALU status flags,
//                evaluates a condition code and fetches a 16-bit target
//                (hi, lo) or skips the operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module jmp_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        flag_we,
    input  logic [7:0]  alu_result,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    input  logic        jmp_start,
    input  logic [3:0]  jmp_cond,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic        mem_req,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        pc_skip,
    output logic        done,
    output logic        taken,
    output logic        busy,
    output logic [3:0]  flags
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_FETCH_HI = 3'd1;
    localparam logic [2:0] c_FETCH_LO = 3'd2;
    localparam logic [2:0] c_LOAD     = 3'd3;
    localparam logic [2:0] c_SKIP     = 3'd4;

    logic [2:0]  r_state;
    logic [3:0]  r_flags;
    logic        r_mem_req;
    logic        r_pc_load;
    logic        r_pc_skip;
    logic        r_done;
    logic        r_taken;
    logic        r_busy;
    logic [15:0] r_pc_value;

    // Flag bit positions inside {S,C,O,Z}
    logic w_s, w_c, w_o, w_z;
    logic w_cond;

    assign w_s = r_flags[3];
    assign w_c = r_flags[2];
    assign w_o = r_flags[1];
    assign w_z = r_flags[0];

    // Condition uses the flags already registered, never a same-cycle update.
    always_comb begin
        w_cond = 1'b0;
        case (jmp_cond)
            4'd0:  w_cond = 1'b1;
            4'd1:  w_cond = w_z;
            4'd2:  w_cond = ~w_z;
            4'd3:  w_cond = w_c;
            4'd4:  w_cond = ~w_c;
            4'd5:  w_cond = w_s;
            4'd6:  w_cond = ~w_s;
            4'd7:  w_cond = w_o;
            4'd8:  w_cond = ~w_o;
            4'd9:  w_cond = w_s ^ w_o;
            4'd10: w_cond = ~(w_s ^ w_o);
            4'd11: w_cond = ~w_z & ~(w_s ^ w_o);
            4'd12: w_cond = w_z | (w_s ^ w_o);
            4'd13: w_cond = w_c & ~w_z;
            4'd14: w_cond = ~w_c | w_z;
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_flags    <= 4'h0;
            r_mem_req  <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_skip  <= 1'b0;
            r_done     <= 1'b0;
            r_taken    <= 1'b0;
            r_busy     <= 1'b0;
            r_pc_value <= 16'h0000;
        end else begin
            r_pc_load <= 1'b0;
            r_pc_skip <= 1'b0;
            r_done    <= 1'b0;

            if (flag_we) begin
                r_flags <= {alu_result[7], alu_carry, alu_overflow,
                            (alu_result == 8'h00)};
            end

            case (r_state)
                c_IDLE: begin
                    if (jmp_start) begin
                        r_taken <= w_cond;
                        r_busy  <= 1'b1;
                        if (w_cond) begin
                            r_state   <= c_FETCH_HI;
                            r_mem_req <= 1'b1;
                        end else begin
                            r_state   <= c_SKIP;
                            r_pc_skip <= 1'b1;
                            r_done    <= 1'b1;
                        end
                    end
                end
                c_FETCH_HI: begin
                    if (mem_valid) begin
                        r_pc_value[15:8] <= mem_data;
                        r_state          <= c_FETCH_LO;
                    end
                end
                c_FETCH_LO: begin
                    if (mem_valid) begin
                        r_pc_value[7:0] <= mem_data;
                        r_state         <= c_LOAD;
                        r_mem_req       <= 1'b0;
                        r_pc_load       <= 1'b1;
                        r_done          <= 1'b1;
                    end
                end
                c_LOAD, c_SKIP: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign pc_load  = r_pc_load;
    assign pc_value = r_pc_value;
    assign pc_skip  = r_pc_skip;
    assign done     = r_done;
    assign taken    = r_taken;
    assign busy     = r_busy;
    assign flags    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_jmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jmp_ctrl
//  Description : Self-checking bench for jmp_ctrl with a transaction-level
//                reference model of flags, conditions and jump timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jmp_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flag_we = 1'b0;
    logic [7:0]  alu_result = 8'h00;
    logic        alu_overflow = 1'b0;
    logic        alu_carry = 1'b0;
    logic        jmp_start = 1'b0;
    logic [3:0]  jmp_cond = 4'h0;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_valid = 1'b0;
    logic        mem_req;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        pc_skip;
    logic        done;
    logic        taken;
    logic        busy;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: flags as individual truth values, last loaded target
    bit          m_s, m_c, m_o, m_z;
    logic [15:0] m_pc;

    jmp_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flag_we      (flag_we),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .jmp_start    (jmp_start),
        .jmp_cond     (jmp_cond),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .mem_req      (mem_req),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .pc_skip      (pc_skip),
        .done         (done),
        .taken        (taken),
        .busy         (busy),
        .flags        (flags)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_holds(input logic [3:0] c);
        bit lt;
        lt = (m_s != m_o);  // signed "less than"
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return m_z;
            4'd2:  return !m_z;
            4'd3:  return m_c;
            4'd4:  return !m_c;
            4'd5:  return m_s;
            4'd6:  return !m_s;
            4'd7:  return m_o;
            4'd8:  return !m_o;
            4'd9:  return lt;
            4'd10: return !lt;
            4'd11: return !m_z && !lt;
            4'd12: return m_z || lt;
            4'd13: return m_c && !m_z;
            4'd14: return !m_c || m_z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_flags(input logic [7:0] res, input bit ov, input bit cy);
        m_z = (res == 0);
        m_s = (res >= 8'd128);
        m_o = ov;
        m_c = cy;
    endfunction

    task automatic set_flags(input logic [7:0] res, input bit ov, input bit cy);
        flag_we = 1'b1; alu_result = res; alu_overflow = ov; alu_carry = cy;
        tick;
        flag_we = 1'b0;
        model_flags(res, ov, cy);
        n_cmp++;
        if (flags !== {m_s, m_c, m_o, m_z}) begin
            n_err++;
            $display("FAIL flags: got %b, want %b", flags, {m_s, m_c, m_o, m_z});
        end
    endtask

    // One whole jump; output vector order {mem_req,pc_load,pc_skip,done,taken,busy}
    task automatic do_jump(input logic [3:0] cond, input logic [7:0] hi, input logic [7:0] lo,
                           input int whi, input int wlo, input bit fwe,
                           input logic [7:0] fres, input bit fov, input bit fcy, input bit poke);
        bit exp_t;
        logic [5:0] obs;
        exp_t = cond_holds(cond);
        jmp_start = 1'b1; jmp_cond = cond;
        flag_we = fwe; alu_result = fres; alu_overflow = fov; alu_carry = fcy;
        tick;
        if (fwe) model_flags(fres, fov, fcy);
        jmp_start = 1'b0; flag_we = 1'b0;
        n_cmp++;
        if (flags !== {m_s, m_c, m_o, m_z}) begin
            n_err++;
            $display("FAIL start_flags: got %b, want %b", flags, {m_s, m_c, m_o, m_z});
        end
        obs = {mem_req, pc_load, pc_skip, done, taken, busy};
        if (!exp_t) begin
            n_cmp++;
            if (obs !== 6'b001101 || pc_value !== m_pc) begin
                n_err++;
                $display("FAIL skip_cycle cond=%0d: got %b pc=%h, want 001101 pc=%h", cond, obs, pc_value, m_pc);
            end
            jmp_start = poke;
            tick;
            jmp_start = 1'b0;
            obs = {mem_req, pc_load, pc_skip, done, taken, busy};
            n_cmp++;
            if (obs !== 6'b000000) begin
                n_err++;
                $display("FAIL skip_end: got %b, want 000000", obs);
            end
        end else begin
            n_cmp++;
            if (obs !== 6'b100011) begin
                n_err++;
                $display("FAIL fetch_hi_entry cond=%0d: got %b, want 100011", cond, obs);
            end
            for (int i = 0; i < whi; i++) begin
                mem_valid = 1'b0; mem_data = 8'($urandom); jmp_start = poke;
                tick;
                obs = {mem_req, pc_load, pc_skip, done, taken, busy};
                n_cmp++;
                if (obs !== 6'b100011) begin
                    n_err++;
                    $display("FAIL wait_hi[%0d]: got %b, want 100011", i, obs);
                end
            end
            jmp_start = 1'b0; mem_valid = 1'b1; mem_data = hi;
            tick;
            obs = {mem_req, pc_load, pc_skip, done, taken, busy};
            n_cmp++;
            if (obs !== 6'b100011 || pc_value[15:8] !== hi) begin
                n_err++;
                $display("FAIL fetch_lo_entry: got %b hi=%h, want 100011 hi=%h", obs, pc_value[15:8], hi);
            end
            for (int i = 0; i < wlo; i++) begin
                mem_valid = 1'b0; mem_data = 8'($urandom); jmp_start = poke;
                tick;
                obs = {mem_req, pc_load, pc_skip, done, taken, busy};
                n_cmp++;
                if (obs !== 6'b100011) begin
                    n_err++;
                    $display("FAIL wait_lo[%0d]: got %b, want 100011", i, obs);
                end
            end
            jmp_start = 1'b0; mem_valid = 1'b1; mem_data = lo;
            tick;
            mem_valid = 1'b0;
            m_pc = {hi, lo};
            obs = {mem_req, pc_load, pc_skip, done, taken, busy};
            n_cmp++;
            if (obs !== 6'b010111 || pc_value !== m_pc) begin
                n_err++;
                $display("FAIL load_cycle: got %b pc=%h, want 010111 pc=%h", obs, pc_value, m_pc);
            end
            jmp_start = poke; mem_valid = poke; mem_data = 8'($urandom);
            tick;
            jmp_start = 1'b0; mem_valid = 1'b0;
            obs = {mem_req, pc_load, pc_skip, done, taken, busy};
            n_cmp++;
            if (obs !== 6'b000010 || pc_value !== m_pc) begin
                n_err++;
                $display("FAIL load_end: got %b pc=%h, want 000010 pc=%h", obs, pc_value, m_pc);
            end
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, pc_load, pc_skip, done, taken, busy, flags, pc_value} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_async: got %b %h %h, want all zero",
                     {mem_req, pc_load, pc_skip, done, taken, busy}, flags, pc_value);
        end
        tick; tick;
        reset = 1'b0;
        m_s = 0; m_c = 0; m_o = 0; m_z = 0; m_pc = 16'h0000;
        tick;
        n_cmp++;
        if ({mem_req, pc_load, pc_skip, done, taken, busy, flags, pc_value} !== 26'h0) begin
            n_err++;
            $display("FAIL reset_release: got %b %h %h, want all zero",
                     {mem_req, pc_load, pc_skip, done, taken, busy}, flags, pc_value);
        end
    endtask

    task automatic test_flags;
        set_flags(8'h00, 1'b0, 1'b1);
        n_cmp++;
        if (flags !== 4'b0101) begin
            n_err++;
            $display("FAIL flags_zero_carry: got %b, want 0101", flags);
        end
        do_jump(4'd1, 8'h12, 8'h34, 0, 0, 0, 8'h00, 0, 0, 0);
        n_cmp++;
        if (pc_value !== 16'h1234) begin
            n_err++;
            $display("FAIL jump_z_target: got %h, want 1234", pc_value);
        end
        do_jump(4'd2, 8'hEE, 8'hEE, 0, 0, 0, 8'h00, 0, 0, 0);
        set_flags(8'h80, 1'b1, 1'b0);
        n_cmp++;
        if (flags !== 4'b1010) begin
            n_err++;
            $display("FAIL flags_sign_ovf: got %b, want 1010", flags);
        end
    endtask

    task automatic test_signed_cond;
        set_flags(8'h80, 1'b0, 1'b0);
        do_jump(4'd9,  8'hA5, 8'h5A, 0, 0, 0, 8'h00, 0, 0, 0);
        do_jump(4'd10, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
        do_jump(4'd9,  8'h77, 8'h01, 0, 0, 1, 8'h01, 0, 0, 0);
        n_cmp++;
        if (taken !== 1'b1 || flags[3] !== 1'b0) begin
            n_err++;
            $display("FAIL old_flag_used: got taken=%b S=%b, want taken=1 S=0", taken, flags[3]);
        end
    endtask

    task automatic test_slow_mem;
        do_jump(4'd0, 8'hC3, 8'h3C, 5, 0, 0, 8'h00, 0, 0, 1);
        tick;
        n_cmp++;
        if ({mem_req, pc_load, pc_skip, done, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL poke_ignored: got %b, want 00000", {mem_req, pc_load, pc_skip, done, busy});
        end
    endtask

    task automatic test_idle_mem;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_data = 8'($urandom);
            tick;
            n_cmp++;
            if (mem_req !== 1'b0 || busy !== 1'b0 || pc_value !== m_pc) begin
                n_err++;
                $display("FAIL idle_mem_valid: got req=%b busy=%b pc=%h, want 0 0 %h", mem_req, busy, pc_value, m_pc);
            end
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_reset_abort;
        set_flags(8'h05, 1'b1, 1'b1);
        jmp_start = 1'b1; jmp_cond = 4'd0;
        tick;
        jmp_start = 1'b0; mem_valid = 1'b1; mem_data = 8'hAB;
        tick;
        mem_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, pc_load, pc_skip, done, taken, busy, flags, pc_value} !== 26'h0) begin
            n_err++;
            $display("FAIL abort_outputs: got %b %h %h, want all zero",
                     {mem_req, pc_load, pc_skip, done, taken, busy}, flags, pc_value);
        end
        mem_valid = 1'b1; mem_data = 8'h55;
        tick;
        reset = 1'b0; mem_valid = 1'b0;
        m_s = 0; m_c = 0; m_o = 0; m_z = 0; m_pc = 16'h0000;
        tick;
        n_cmp++;
        if ({mem_req, pc_load, pc_skip, done, busy, pc_value} !== 21'h0) begin
            n_err++;
            $display("FAIL abort_no_strobe: got %b %h, want all zero",
                     {mem_req, pc_load, pc_skip, done, busy}, pc_value);
        end
        do_jump(4'd0, 8'h00, 8'h10, 0, 0, 0, 8'h00, 0, 0, 0);
        n_cmp++;
        if (pc_value !== 16'h0010) begin
            n_err++;
            $display("FAIL abort_rejump: got %h, want 0010", pc_value);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                set_flags(8'($urandom), 1'($urandom), 1'($urandom));
            do_jump(4'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_flags;
        test_signed_cond;
        test_slow_mem;
        test_idle_mem;
        test_reset_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
